demultiplexer: RTL

Avalon-ST 1-to-2 packet demultiplexer; sits directly downstream of `multiplexer` and consumes its merged output stream. Each packet is routed whole to output one or output two by the MSB of the channel sampled on its start-of-packet beat. Each output has a one-deep registered slice, giving 1-cycle latency at full throughput.

---
 rtl/avalon_st_pkg.sv | 24 ++
 rtl/avalon_st_slice.sv | 37 +++
 rtl/demultiplexer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/avalon_st_pkg.sv
// Shared Avalon-ST definitions for the packet demultiplexer: the default beat
// payload layout and the packet-tracking state encoding.
package avalon_st_pkg;

  localparam int AVST_CHANNEL_W = 8;
  localparam int AVST_DATA_W    = 32;
  localparam int AVST_EMPTY_W   = $clog2(AVST_DATA_W / 8);

  // One Avalon-ST beat without its valid qualifier.
  typedef struct packed {
    logic [AVST_CHANNEL_W-1:0] channel;
    logic [AVST_DATA_W-1:0]    data;
    logic                      sop;
    logic                      eop;
    logic [AVST_EMPTY_W-1:0]   empty;
  } avalon_item;

  // IDLE waits for the first beat of a packet; IN_PKT follows the latched route.
  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } demux_state_t;

endpackage

// File: rtl/avalon_st_slice.sv
// One-deep registered Avalon-ST output slot. The upstream only asserts load_i
// when the slot is empty or being drained in the same cycle, so a loaded beat
// never overwrites one that has not been handed off.
module avalon_st_slice
  import avalon_st_pkg::*;
#(
  parameter type item_t = avalon_item
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load_i,
  input  item_t item_i,
  output logic  valid_o,
  output item_t item_o,
  input  logic  ready_i
);

  logic  valid_q;
  item_t item_q;

  // Capture a new beat on load; otherwise drop valid once downstream takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      item_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      item_q  <= item_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign item_o  = item_q;

endmodule

// File: rtl/demultiplexer.sv
// Avalon-ST 1-to-2 packet demultiplexer. Whole packets are steered to output
// one (channel MSB = 0) or output two (channel MSB = 1) according to the
// channel seen on the packet's first beat; each output is a one-deep slice.
// Optional feature macro: DEMUX_FRAME_CHECK_EN adds framing checks and the
// frame_err pulse output.
module demultiplexer
  import avalon_st_pkg::*;
#(
  parameter int channel_width = AVST_CHANNEL_W,
  parameter int data_width    = AVST_DATA_W,
  parameter int empty_width   = $clog2(data_width / 8)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [channel_width-1:0] avsi_channel,
  input  logic [data_width-1:0]    avsi_data,
  input  logic                     avsi_valid,
  input  logic                     avsi_sop,
  input  logic                     avsi_eop,
  input  logic [empty_width-1:0]   avsi_empty,
  output logic                     avsi_ready,
  output logic [channel_width-1:0] avso_one_channel,
  output logic [data_width-1:0]    avso_one_data,
  output logic                     avso_one_valid,
  output logic                     avso_one_sop,
  output logic                     avso_one_eop,
  output logic [empty_width-1:0]   avso_one_empty,
  input  logic                     avso_one_ready,
  output logic [channel_width-1:0] avso_two_channel,
  output logic [data_width-1:0]    avso_two_data,
  output logic                     avso_two_valid,
  output logic                     avso_two_sop,
  output logic                     avso_two_eop,
  output logic [empty_width-1:0]   avso_two_empty,
`ifdef DEMUX_FRAME_CHECK_EN
  input  logic                     avso_two_ready,
  output logic                     frame_err
`else
  input  logic                     avso_two_ready
`endif
);

  typedef struct packed {
    logic [channel_width-1:0] channel;
    logic [data_width-1:0]    data;
    logic                     sop;
    logic                     eop;
    logic [empty_width-1:0]   empty;
  } beat_t;

  demux_state_t state_q, state_d;
  logic         route_q, route_d;

  beat_t inBeat, oneBeat, twoBeat;
  logic  oneValid, twoValid;
  logic  chanSel, startPkt, discard, sel;
  logic  selValid, selReady, accept, load;

  assign inBeat  = '{channel: avsi_channel, data: avsi_data, sop: avsi_sop,
                     eop: avsi_eop, empty: avsi_empty};
  assign chanSel = avsi_channel[channel_width-1];

  // A sop always opens a new packet. Without framing checks a stray non-sop
  // beat in IDLE is treated as a packet start; with them it is dropped.
`ifdef DEMUX_FRAME_CHECK_EN
  assign startPkt = avsi_sop;
  assign discard  = (state_q == IDLE) && !avsi_sop;
`else
  assign startPkt = avsi_sop || (state_q == IDLE);
  assign discard  = 1'b0;
`endif

  // Packet starts route by their own channel MSB; continuation beats follow
  // the route latched at the start, whatever channel they carry.
  assign sel      = startPkt ? chanSel : route_q;
  assign selValid = sel ? twoValid : oneValid;
  assign selReady = sel ? avso_two_ready : avso_one_ready;

  // Only the selected slot can back-pressure the input; dropped beats never stall.
  assign avsi_ready = reset_n && (discard || !selValid || selReady);
  assign accept     = avsi_valid && avsi_ready;
  assign load       = accept && !discard;

  avalon_st_slice #(.item_t(beat_t)) u_slice_one (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load && !sel),
    .item_i  (inBeat),
    .valid_o (oneValid),
    .item_o  (oneBeat),
    .ready_i (avso_one_ready)
  );

  avalon_st_slice #(.item_t(beat_t)) u_slice_two (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load && sel),
    .item_i  (inBeat),
    .valid_o (twoValid),
    .item_o  (twoBeat),
    .ready_i (avso_two_ready)
  );

`ifdef DEMUX_FRAME_CHECK_EN
  logic frameErr_q, frameErr_d;
  assign frameErr_d = accept && (discard || ((state_q == IN_PKT) && avsi_sop));
  assign frame_err  = frameErr_q;
`endif

  // Next packet state and route, advanced only by beats that reach a slot.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (load) begin
      if (startPkt && !avsi_eop) begin
        state_d = IN_PKT;
        route_d = sel;
      end else if (avsi_eop) begin
        state_d = IDLE;
      end
    end
  end

  // Packet-tracking registers, plus the framing-error pulse when enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      route_q    <= 1'b0;
`ifdef DEMUX_FRAME_CHECK_EN
      frameErr_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
`ifdef DEMUX_FRAME_CHECK_EN
      frameErr_q <= frameErr_d;
`endif
    end
  end

  assign avso_one_valid   = oneValid;
  assign avso_one_channel = oneBeat.channel;
  assign avso_one_data    = oneBeat.data;
  assign avso_one_sop     = oneBeat.sop;
  assign avso_one_eop     = oneBeat.eop;
  assign avso_one_empty   = oneBeat.empty;

  assign avso_two_valid   = twoValid;
  assign avso_two_channel = twoBeat.channel;
  assign avso_two_data    = twoBeat.data;
  assign avso_two_sop     = twoBeat.sop;
  assign avso_two_eop     = twoBeat.eop;
  assign avso_two_empty   = twoBeat.empty;

endmodule
